mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Boot-time loader in front of cpumemory. Drives cpumemory's mw/addr/data_in ports.
- Receives a framed byte stream over a valid/ready interface, for example from a UART receiver.
- Writes the stream's payload into memory while holding the 6502 core in hold, then hands the memory port to the CPU.
- After handover the block is a transparent mux from the CPU bus to memory.

Parameters:
MEM_SIZE, 2048, number of bytes in cpumemory; upper bound for any load.
ADDR_W, 16, address width (matches addr_t).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  stream byte valid
rx_data  input  8  stream byte
rx_ready  output  1  loader accepts byte this cycle
cpu_mw  input  mw_t  CPU read/write request
cpu_addr  input  16  CPU address
cpu_data  input  8  CPU write data
mem_mw  output  mw_t  to cpumemory mw
mem_addr  output  16  to cpumemory addr
mem_data_in  output  8  to cpumemory data_in
cpu_hold  output  1  1 = CPU stalled/held in reset
load_done  output  1  sticky, load completed OK
load_err  output  1  sticky, load failed

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - State = ADDR_LO.
  - rx_ready=1, cpu_hold=1, load_done=0, load_err=0.
  - mem_mw=READ, mem_addr=0, mem_data_in=0.
  - Internal start/len/count/sum = 0.
- Handshake: a byte is accepted on a cycle with rx_valid & rx_ready. One byte per cycle maximum.
- Frame format, in order:
  - ADDR_LO, ADDR_HI: start address, little endian.
  - LEN_LO, LEN_HI: byte count L, little endian.
  - L data bytes.
  - One checksum byte.
- FSM states: ADDR_LO -> ADDR_HI -> LEN_LO -> LEN_HI -> DATA -> CSUM -> DONE | ERROR.
  - Each transition advances only on an accepted byte.
  - rx_ready=1 in ADDR_LO through CSUM; rx_ready=0 in DONE and ERROR.
- On acceptance of LEN_HI:
  - If start + L > MEM_SIZE (computed at 17 bits, no wrap), go to ERROR.
  - Else if L == 0, go to CSUM.
  - Else go to DATA.
- DATA writes:
  - A byte accepted at cycle N produces, at N+1 (registered), one cycle of mem_mw=WRITE, mem_addr=start+count, mem_data_in=byte.
  - count then increments.
  - sum = (sum + byte) mod 256.
  - On the L-th byte, go to CSUM.
- Idle loading cycles: on any cycle with no write during loading, mem_mw=READ and mem_addr/mem_data_in hold their last values.
- CSUM:
  - An accepted byte equal to sum goes to DONE; otherwise it goes to ERROR.
  - For L=0 the required checksum is 0x00.
- DONE (entered at cycle N+1 after the checksum is accepted at N):
  - cpu_hold=0, load_done=1.
  - mem_mw/mem_addr/mem_data_in follow cpu_mw/cpu_addr/cpu_data combinationally, with no added latency.
  - Remains in DONE until reset.
- ERROR:
  - load_err=1, cpu_hold=1, mem_mw=READ.
  - No further writes; stream ignored until reset.
- Reset mid-frame: all progress is discarded and the next byte is treated as ADDR_LO. A pending write registered before reset does not occur after reset.
- rx_valid while rx_ready=0: byte ignored, no state change.
- Counters: count is 16 bits. The start+count address cannot exceed MEM_SIZE-1 because of the LEN_HI check.

Test Plan:
- Nominal load: stream 00 01 03 00 A9 05 60 0E.
  - Expect writes 0x0100=A9, 0x0101=05, 0x0102=60 on consecutive cycles, each 1 cycle after acceptance.
  - Expect cpu_hold fall and load_done=1 one cycle after the 0E byte.
  - Read back via the CPU mux: cpu_addr=0x0101 returns 05 from cpumemory.
- Bad checksum: same frame with final byte 0F.
  - Expect three writes, then load_err=1, cpu_hold stays 1, rx_ready=0, load_done=0.
- Bounds: stream FE 07 03 00 (start 0x07FE + 3 > 2048).
  - Expect ERROR immediately after LEN_HI, zero writes.
  - Repeat with FD 07 03 00 ..: succeeds, last write at 0x07FF.
- Zero length: stream 20 00 00 00 00.
  - Expect no writes, load_done=1.
  - Same header with checksum 01 gives load_err=1.
- Gapped stream plus reset: toggle rx_valid 1-0-1 randomly during the nominal frame; writes occur only on accepted bytes.
  - Then assert rst_n=0 mid-data, release, send the nominal frame: exactly 3 writes, load_done=1.
- Post-DONE passthrough: drive cpu_mw=WRITE, cpu_addr=0x0010, cpu_data=5A.
  - Expect mem_* to equal the cpu inputs in the same cycle.
  - Stray rx_valid bytes cause no writes.

Source files
------------

// File: rtl/mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_if
// Description : Stream, CPU-bus and memory-port bundle for mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              cpu_mw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_data;
    logic              mem_mw;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_in;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  rx_valid, rx_data, cpu_mw, cpu_addr, cpu_data,
        output rx_ready, mem_mw, mem_addr, mem_data_in, cpu_hold, load_done, load_err
    );

    modport master (
        output rx_valid, rx_data, cpu_mw, cpu_addr, cpu_data,
        input  rx_ready, mem_mw, mem_addr, mem_data_in, cpu_hold, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Boot loader writing a framed byte stream into cpumemory while
//               the CPU is held, then muxing the CPU bus onto the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int MEM_SIZE = 2048,
    parameter int ADDR_W   = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_loader_if.slave   bus
);
    localparam logic c_MW_READ  = 1'b0;
    localparam logic c_MW_WRITE = 1'b1;

    localparam logic [2:0] c_ST_ADDR_LO = 3'd0;
    localparam logic [2:0] c_ST_ADDR_HI = 3'd1;
    localparam logic [2:0] c_ST_LEN_LO  = 3'd2;
    localparam logic [2:0] c_ST_LEN_HI  = 3'd3;
    localparam logic [2:0] c_ST_DATA    = 3'd4;
    localparam logic [2:0] c_ST_CSUM    = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;
    localparam logic [2:0] c_ST_ERROR   = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_start;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [7:0]        r_sum;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic              w_rx_ready;
    logic              w_accept;
    logic [15:0]       w_len_full;
    logic [ADDR_W:0]   w_end;
    logic              w_oob;
    logic              w_last_data;

    logic              w_mem_mw;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [7:0]        w_mem_data;
    logic              w_cpu_hold;
    logic              w_load_done;
    logic              w_load_err;

    assign w_accept    = bus.rx_valid & w_rx_ready;
    assign w_len_full  = {bus.rx_data, r_len[7:0]};
    // End address at one extra bit so a frame that wraps the address space is still rejected.
    assign w_end       = {1'b0, r_start} + (ADDR_W+1)'(w_len_full);
    assign w_oob       = w_end > (ADDR_W+1)'(MEM_SIZE);
    assign w_last_data = (r_count + 16'd1) == r_len;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_ADDR_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                c_ST_ADDR_LO: w_state_nxt = c_ST_ADDR_HI;
                c_ST_ADDR_HI: w_state_nxt = c_ST_LEN_LO;
                c_ST_LEN_LO:  w_state_nxt = c_ST_LEN_HI;
                c_ST_LEN_HI: begin
                    if (w_oob) begin
                        w_state_nxt = c_ST_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        w_state_nxt = c_ST_CSUM;
                    end else begin
                        w_state_nxt = c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_last_data) begin
                        w_state_nxt = c_ST_CSUM;
                    end
                end
                c_ST_CSUM: w_state_nxt = (bus.rx_data == r_sum) ? c_ST_DONE : c_ST_ERROR;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_rx_ready  = 1'b1;
        w_cpu_hold  = 1'b1;
        w_load_done = 1'b0;
        w_load_err  = 1'b0;
        w_mem_mw    = r_wr_en ? c_MW_WRITE : c_MW_READ;
        w_mem_addr  = r_wr_addr;
        w_mem_data  = r_wr_data;
        case (r_state)
            c_ST_DONE: begin
                w_rx_ready  = 1'b0;
                w_cpu_hold  = 1'b0;
                w_load_done = 1'b1;
                w_mem_mw    = bus.cpu_mw;
                w_mem_addr  = bus.cpu_addr;
                w_mem_data  = bus.cpu_data;
            end
            c_ST_ERROR: begin
                w_rx_ready = 1'b0;
                w_load_err = 1'b1;
                w_mem_mw   = c_MW_READ;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame datapath and registered write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start   <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_sum     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    c_ST_ADDR_LO: r_start <= ADDR_W'({r_start[15:8], bus.rx_data});
                    c_ST_ADDR_HI: r_start <= ADDR_W'({bus.rx_data, r_start[7:0]});
                    c_ST_LEN_LO:  r_len   <= {r_len[15:8], bus.rx_data};
                    c_ST_LEN_HI:  r_len   <= w_len_full;
                    c_ST_DATA: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_start + ADDR_W'(r_count);
                        r_wr_data <= bus.rx_data;
                        r_count   <= r_count + 16'd1;
                        r_sum     <= r_sum + bus.rx_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready    = w_rx_ready;
    assign bus.mem_mw      = w_mem_mw;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_data_in = w_mem_data;
    assign bus.cpu_hold    = w_cpu_hold;
    assign bus.load_done   = w_load_done;
    assign bus.load_err    = w_load_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Directed self-checking bench for mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   cyc;

    int          acc_cyc[$];
    int          wr_cyc[$];
    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic [7:0]  fq[$];
    logic [7:0]  tbmem[0:2047];

    mem_loader_if bus ();

    mem_loader #(.MEM_SIZE(2048), .ADDR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation point is the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid && bus.rx_ready) acc_cyc.push_back(cyc);
            if (bus.mem_mw) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(bus.mem_addr);
                wr_data.push_back(bus.mem_data_in);
                tbmem[bus.mem_addr[10:0]] = bus.mem_data_in;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        acc_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cpu_mw   = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_data = 8'h00;
        rst_n = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int gap_max);
        foreach (fq[i]) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                for (int k = 0; k < g; k++) begin
                    bus.rx_valid = 1'b0;
                    bus.rx_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = fq[i];
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic check_nominal_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3 && acc_cyc.size() >= 7) begin
            check({tag, "_a0"}, 32'(wr_addr[0]), 32'h0100);
            check({tag, "_d0"}, 32'(wr_data[0]), 32'hA9);
            check({tag, "_a1"}, 32'(wr_addr[1]), 32'h0101);
            check({tag, "_d1"}, 32'(wr_data[1]), 32'h05);
            check({tag, "_a2"}, 32'(wr_addr[2]), 32'h0102);
            check({tag, "_d2"}, 32'(wr_data[2]), 32'h60);
            for (int i = 0; i < 3; i++)
                check({tag, "_lat"}, 32'(wr_cyc[i] - acc_cyc[4+i]), 32'd1);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 2048; i++) tbmem[i] = 8'h00;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_hold",  32'(bus.cpu_hold), 32'd1);
        check("rst_done",  32'(bus.load_done), 32'd0);
        check("rst_err",   32'(bus.load_err), 32'd0);
        check("rst_mw",    32'(bus.mem_mw), 32'd0);
        check("rst_addr",  32'(bus.mem_addr), 32'd0);
        check("rst_data",  32'(bus.mem_data_in), 32'd0);
        @(posedge clk);
        #1;

        // Nominal load, hold released one cycle after checksum
        fq = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hA9, 8'h05, 8'h60};
        send_frame(0);
        @(negedge clk);
        check("nom_hold_pre", 32'(bus.cpu_hold), 32'd1);
        @(posedge clk);
        #1;
        fq = '{8'h0E};
        send_frame(0);
        @(negedge clk);
        check_nominal_writes("nom");
        check("nom_hold", 32'(bus.cpu_hold), 32'd0);
        check("nom_done", 32'(bus.load_done), 32'd1);
        check("nom_err",  32'(bus.load_err), 32'd0);
        check("nom_ready", 32'(bus.rx_ready), 32'd0);
        bus.cpu_mw   = 1'b0;
        bus.cpu_addr = 16'h0101;
        #1;
        check("nom_rd_addr", 32'(bus.mem_addr), 32'h0101);
        check("nom_rd_data", 32'(tbmem[bus.mem_addr[10:0]]), 32'h05);

        // Post-DONE: stray stream bytes, then combinational passthrough
        @(posedge clk);
        #1;
        clear_log();
        fq = '{8'h11, 8'h22, 8'h33};
        send_frame(0);
        @(negedge clk);
        check("pt_stray_acc", 32'(acc_cyc.size()), 32'd0);
        check("pt_stray_wr",  32'(wr_addr.size()), 32'd0);
        bus.cpu_mw   = 1'b1;
        bus.cpu_addr = 16'h0010;
        bus.cpu_data = 8'h5A;
        #1;
        check("pt_mw",   32'(bus.mem_mw), 32'd1);
        check("pt_addr", 32'(bus.mem_addr), 32'h0010);
        check("pt_data", 32'(bus.mem_data_in), 32'h5A);
        bus.cpu_mw = 1'b0;

        // Bad checksum
        do_reset();
        fq = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hA9, 8'h05, 8'h60, 8'h0F};
        send_frame(0);
        @(negedge clk);
        check_nominal_writes("bad");
        check("bad_err",   32'(bus.load_err), 32'd1);
        check("bad_hold",  32'(bus.cpu_hold), 32'd1);
        check("bad_ready", 32'(bus.rx_ready), 32'd0);
        check("bad_done",  32'(bus.load_done), 32'd0);
        check("bad_mw",    32'(bus.mem_mw), 32'd0);

        // Out-of-bounds header
        do_reset();
        fq = '{8'hFE, 8'h07, 8'h03, 8'h00};
        send_frame(0);
        @(negedge clk);
        check("oob_err",  32'(bus.load_err), 32'd1);
        check("oob_hold", 32'(bus.cpu_hold), 32'd1);
        @(posedge clk);
        #1;
        fq = '{8'h11, 8'h22, 8'h33, 8'h66};
        send_frame(0);
        @(negedge clk);
        check("oob_nwr", 32'(wr_addr.size()), 32'd0);
        check("oob_acc", 32'(acc_cyc.size()), 32'd4);

        // Load ending exactly at the last byte of memory
        do_reset();
        fq = '{8'hFD, 8'h07, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        send_frame(0);
        @(negedge clk);
        check("edge_nwr",  32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            check("edge_a0", 32'(wr_addr[0]), 32'h07FD);
            check("edge_a2", 32'(wr_addr[2]), 32'h07FF);
            check("edge_d2", 32'(wr_data[2]), 32'h33);
        end
        check("edge_done", 32'(bus.load_done), 32'd1);

        // Zero length, good and bad checksum
        do_reset();
        fq = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        @(negedge clk);
        check("zl_nwr",  32'(wr_addr.size()), 32'd0);
        check("zl_done", 32'(bus.load_done), 32'd1);
        do_reset();
        fq = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h01};
        send_frame(0);
        @(negedge clk);
        check("zl_bad_err",  32'(bus.load_err), 32'd1);
        check("zl_bad_done", 32'(bus.load_done), 32'd0);

        // Gapped nominal stream
        do_reset();
        fq = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hA9, 8'h05, 8'h60, 8'h0E};
        send_frame(2);
        @(negedge clk);
        check_nominal_writes("gap");
        check("gap_done", 32'(bus.load_done), 32'd1);

        // Reset mid-data discards progress and the pending write
        do_reset();
        fq = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hA9};
        send_frame(0);
        do_reset();
        @(negedge clk);
        check("mid_nwr",  32'(wr_addr.size()), 32'd0);
        check("mid_mw",   32'(bus.mem_mw), 32'd0);
        check("mid_ready", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        clear_log();
        fq = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hA9, 8'h05, 8'h60, 8'h0E};
        send_frame(0);
        @(negedge clk);
        check_nominal_writes("mid");
        check("mid_done", 32'(bus.load_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
